btn_cmd_sched: RTL and testbench

Command scheduler between the three debounced button pulse outputs and the stopwatch/ultrasonic control FSM. It latches each button event into a pending flag and arbitrates simultaneous or back-to-back events. It issues them one at a time as encoded commands over a valid/ready handshake, then enforces a hold-off gap before the next command. No button event is lost unless the same button fires again while its earlier event is still pending, and that case is flagged.

---
 rtl/btn_cmd_sched_if.sv | 26 ++
 rtl/btn_cmd_sched.sv | 192 +++++++++++++++++++
 tb/tb_btn_cmd_sched.sv | 295 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/btn_cmd_sched_if.sv
`default_nettype none
// ============================================================================
// Module      : btn_cmd_sched_if
// Description : Command valid/ready handshake between btn_cmd_sched
//               (master, command source) and the control FSM (slave).
//               Signal names are taken from the scheduler's point of view.
// Revision    : 1.0 - initial release
// ============================================================================
interface btn_cmd_sched_if;
  logic       o_cmd_valid;
  logic [1:0] o_cmd;
  logic       i_cmd_ready;

  modport master (
    output o_cmd_valid,
    output o_cmd,
    input  i_cmd_ready
  );

  modport slave (
    input  o_cmd_valid,
    input  o_cmd,
    output i_cmd_ready
  );
endinterface
`default_nettype wire

// File: rtl/btn_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : btn_cmd_sched
// Description : Latches debounced button pulses into pending flags, arbitrates
//               among them and issues one encoded command at a time over a
//               valid/ready handshake. After each accepted command it waits
//               HOLDOFF idle cycles. A pulse on a button whose earlier event
//               is still pending is dropped and reported on o_overrun.
//               Optional macro BTN_CMD_SCHED_RR_EN selects round-robin
//               arbitration; otherwise fixed priority clear > run > mode.
// Revision    : 1.0 - initial release
// ============================================================================
module btn_cmd_sched #(
  parameter int HOLDOFF = 1000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  i_btn_clear,
  input  logic                  i_btn_run,
  input  logic                  i_btn_mode,
  btn_cmd_sched_if.master       cmd_if,
  output logic [2:0]            o_pending,
  output logic                  o_overrun
);

  // Counter must be able to hold HOLDOFF itself (it increments on the exit
  // cycle); a one-bit counter is kept when the gap is disabled.
  localparam int CNT_W      = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam int C_LAST_INT = (HOLDOFF > 0) ? (HOLDOFF - 1) : 0;
  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(C_LAST_INT);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_HOLD  = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [2:0]       r_pend;
  logic [2:0]       w_pend_nxt;
  logic             r_overrun;
  logic             w_overrun_nxt;
  logic             r_cmd_valid;
  logic             w_cmd_valid_nxt;
  logic [1:0]       r_cmd;
  logic [1:0]       w_cmd_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_btn;
  logic [2:0]       w_arb;
  logic [2:0]       w_grant;
  logic [1:0]       w_arb_code;

  // Bit order everywhere is {mode, run, clear}.
  assign w_btn = {i_btn_mode, i_btn_run, i_btn_clear};

`ifdef BTN_CMD_SCHED_RR_EN
  // Index of the last granted button: 0 clear, 1 run, 2 mode.
  logic [1:0] r_ptr;
  logic [1:0] w_grant_idx;

  // Round-robin pick: search starts at the button after the last grant.
  always_comb begin
    w_arb = 3'b000;
    case (r_ptr)
      2'd0: begin
        if      (r_pend[1]) w_arb = 3'b010;
        else if (r_pend[2]) w_arb = 3'b100;
        else if (r_pend[0]) w_arb = 3'b001;
      end
      2'd1: begin
        if      (r_pend[2]) w_arb = 3'b100;
        else if (r_pend[0]) w_arb = 3'b001;
        else if (r_pend[1]) w_arb = 3'b010;
      end
      default: begin
        if      (r_pend[0]) w_arb = 3'b001;
        else if (r_pend[1]) w_arb = 3'b010;
        else if (r_pend[2]) w_arb = 3'b100;
      end
    endcase
  end

  // Convert the one-hot grant into a pointer index.
  always_comb begin
    w_grant_idx = 2'd2;
    if      (w_grant[0]) w_grant_idx = 2'd0;
    else if (w_grant[1]) w_grant_idx = 2'd1;
  end

  // Pointer starts at mode so that clear wins first after reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)      r_ptr <= 2'd2;
    else if (|w_grant) r_ptr <= w_grant_idx;
  end
`else
  // Fixed priority pick: clear > run > mode.
  always_comb begin
    w_arb = 3'b000;
    if      (r_pend[0]) w_arb = 3'b001;
    else if (r_pend[1]) w_arb = 3'b010;
    else if (r_pend[2]) w_arb = 3'b100;
  end
`endif

  // Encode the arbitration winner as a command code.
  always_comb begin
    w_arb_code = 2'b00;
    case (w_arb)
      3'b001:  w_arb_code = 2'b10;
      3'b010:  w_arb_code = 2'b01;
      3'b100:  w_arb_code = 2'b11;
      default: w_arb_code = 2'b00;
    endcase
  end

  // Next-state and next-output logic of the issue FSM.
  always_comb begin
    w_state_nxt     = r_state;
    w_grant         = 3'b000;
    w_cmd_valid_nxt = r_cmd_valid;
    w_cmd_nxt       = r_cmd;
    w_cnt_nxt       = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (|r_pend) begin
          w_grant         = w_arb;
          w_cmd_valid_nxt = 1'b1;
          w_cmd_nxt       = w_arb_code;
          w_state_nxt     = S_ISSUE;
        end else begin
          w_cmd_valid_nxt = 1'b0;
          w_cmd_nxt       = 2'b00;
        end
      end
      S_ISSUE: begin
        if (cmd_if.i_cmd_ready) begin
          w_cmd_valid_nxt = 1'b0;
          w_cmd_nxt       = 2'b00;
          w_cnt_nxt       = '0;
          w_state_nxt     = (HOLDOFF == 0) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        w_cnt_nxt = r_cnt + 1'b1;
        if (r_cnt == c_cnt_last) w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt     = S_IDLE;
        w_cmd_valid_nxt = 1'b0;
        w_cmd_nxt       = 2'b00;
      end
    endcase
  end

  // A same-cycle pulse on the granted button re-arms its flag (set wins).
  always_comb begin
    w_pend_nxt    = (r_pend & ~w_grant) | w_btn;
    w_overrun_nxt = |(w_btn & r_pend & ~w_grant);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Registered outputs, pending flags and hold counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend      <= 3'b000;
      r_overrun   <= 1'b0;
      r_cmd_valid <= 1'b0;
      r_cmd       <= 2'b00;
      r_cnt       <= '0;
    end else begin
      r_pend      <= w_pend_nxt;
      r_overrun   <= w_overrun_nxt;
      r_cmd_valid <= w_cmd_valid_nxt;
      r_cmd       <= w_cmd_nxt;
      r_cnt       <= w_cnt_nxt;
    end
  end

  assign cmd_if.o_cmd_valid = r_cmd_valid;
  assign cmd_if.o_cmd       = r_cmd;
  assign o_pending          = r_pend;
  assign o_overrun          = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_btn_cmd_sched.sv
`default_nettype none
// ============================================================================
// Module      : tb_btn_cmd_sched
// Description : Self-checking bench for btn_cmd_sched with HOLDOFF=4.
//               A cycle-based reference model predicts every output; directed
//               scenarios add hand-computed expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_btn_cmd_sched;
  localparam int HOLDOFF = 4;

  logic       clk     = 1'b0;
  logic       rst_n   = 1'b0;
  logic       b_clear = 1'b0;
  logic       b_run   = 1'b0;
  logic       b_mode  = 1'b0;
  logic [2:0] pending;
  logic       overrun;

  btn_cmd_sched_if u_if ();

  btn_cmd_sched #(.HOLDOFF(HOLDOFF)) dut (
    .clk         (clk),
    .reset_n     (rst_n),
    .i_btn_clear (b_clear),
    .i_btn_run   (b_run),
    .i_btn_mode  (b_mode),
    .cmd_if      (u_if),
    .o_pending   (pending),
    .o_overrun   (overrun)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  logic cmp_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  // Commands are allowed only at or after m_earliest; an accepted command
  // at cycle a pushes that to a + HOLDOFF + 1 (HOLDOFF idle cycles).
  logic       m_valid    = 1'b0;
  logic [1:0] m_cmd      = 2'b00;
  logic [2:0] m_pend     = 3'b000;
  logic       m_ovr      = 1'b0;
  int         m_cyc      = 0;
  int         m_earliest = 0;
  int         m_last     = 2;
  logic [2:0] m_b;
  logic [2:0] m_g;
  int         m_w;
  logic [1:0] code_of [3] = '{2'b10, 2'b01, 2'b11};

  function automatic int pick(input logic [2:0] p, input int last);
    int idx;
`ifdef BTN_CMD_SCHED_RR_EN
    for (int k = 1; k <= 3; k++) begin
      idx = (last + k) % 3;
      if (p[idx]) return idx;
    end
`else
    for (int k = 0; k < 3; k++) begin
      idx = k + (last - last);
      if (p[idx]) return idx;
    end
`endif
    return 0;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid    = 1'b0;
      m_cmd      = 2'b00;
      m_pend     = 3'b000;
      m_ovr      = 1'b0;
      m_earliest = 0;
      m_last     = 2;
    end else begin
      m_b = {b_mode, b_run, b_clear};
      m_g = 3'b000;
      if (m_valid) begin
        if (u_if.i_cmd_ready) begin
          m_valid    = 1'b0;
          m_cmd      = 2'b00;
          m_earliest = m_cyc + HOLDOFF + 1;
        end
      end else if (m_cyc >= m_earliest && m_pend != 3'b000) begin
        m_w      = pick(m_pend, m_last);
        m_g[m_w] = 1'b1;
        m_last   = m_w;
        m_valid  = 1'b1;
        m_cmd    = code_of[m_w];
      end
      m_ovr  = |(m_b & m_pend & ~m_g);
      m_pend = (m_pend & ~m_g) | m_b;
      m_cyc++;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("model_valid",   u_if.o_cmd_valid, m_valid);
      chk("model_cmd",     u_if.o_cmd,       m_cmd);
      chk("model_pending", pending,          m_pend);
      chk("model_overrun", overrun,          m_ovr);
    end
  end

  // ---------------- monitors ----------------
  logic [1:0] acc_cmd [$];
  int         acc_cyc [$];
  int         tb_cyc    = 0;
  int         ovr_cnt   = 0;
  int         valid_cnt = 0;

  always @(posedge clk) begin
    tb_cyc++;
    if (rst_n && u_if.o_cmd_valid && u_if.i_cmd_ready) begin
      acc_cmd.push_back(u_if.o_cmd);
      acc_cyc.push_back(tb_cyc);
    end
    if (rst_n && overrun)           ovr_cnt++;
    if (rst_n && u_if.o_cmd_valid)  valid_cnt++;
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse(input logic [2:0] m);
    {b_mode, b_run, b_clear} = m;
    @(negedge clk);
    {b_mode, b_run, b_clear} = 3'b000;
  endtask

  task automatic wait_valid(input string name);
    int k;
    k = 0;
    while (!u_if.o_cmd_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk(name, u_if.o_cmd_valid, 1'b1);
  endtask

  logic [1:0] exp6 [6] = '{2'b10, 2'b01, 2'b11, 2'b10, 2'b01, 2'b11};
  int acc_n;

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    u_if.i_cmd_ready = 1'b0;
    cycles(2);
    // Reset state.
    chk("rst_valid",   u_if.o_cmd_valid, 1'b0);
    chk("rst_cmd",     u_if.o_cmd,       2'b00);
    chk("rst_pending", pending,          3'b000);
    chk("rst_overrun", overrun,          1'b0);
    rst_n  = 1'b1;
    cmp_en = 1'b1;
    cycles(2);

    // All three at once, twice: order and spacing.
    u_if.i_cmd_ready = 1'b1;
    acc_cmd.delete();
    acc_cyc.delete();
    ovr_cnt = 0;
    pulse(3'b111);
    cycles(20);
    pulse(3'b111);
    cycles(22);
    chk("all3_count", acc_cmd.size(), 6);
    if (acc_cmd.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("all3_order", acc_cmd[i], exp6[i]);
      for (int i = 1; i < 6; i++)
        if (i != 3) chk("all3_spacing", acc_cyc[i] - acc_cyc[i-1], HOLDOFF + 2);
    end
    chk("all3_no_overrun", ovr_cnt, 0);

    // Single run press: latency and hold-off gap with a press during HOLD.
    pulse(3'b010);
    chk("single_pend_t1",  pending,          3'b010);
    chk("single_valid_t1", u_if.o_cmd_valid, 1'b0);
    @(negedge clk);
    chk("single_valid_t2", u_if.o_cmd_valid, 1'b1);
    chk("single_cmd_t2",   u_if.o_cmd,       2'b01);
    chk("single_pend_t2",  pending,          3'b000);
    b_run = 1'b1;
    @(negedge clk);
    b_run = 1'b0;
    chk("single_cmd_t3",   u_if.o_cmd,       2'b00);
    for (int i = 3; i <= 7; i++) begin
      chk("hold_gap_valid", u_if.o_cmd_valid, 1'b0);
      @(negedge clk);
    end
    chk("after_hold_valid", u_if.o_cmd_valid, 1'b1);
    chk("after_hold_cmd",   u_if.o_cmd,       2'b01);
    cycles(10);

    // Backpressure: command held stable 20 cycles.
    u_if.i_cmd_ready = 1'b0;
    pulse(3'b001);
    wait_valid("bp_timeout");
    for (int i = 0; i < 20; i++) begin
      chk("bp_valid", u_if.o_cmd_valid, 1'b1);
      chk("bp_cmd",   u_if.o_cmd,       2'b10);
      @(negedge clk);
    end
    acc_n = acc_cmd.size();
    u_if.i_cmd_ready = 1'b1;
    @(negedge clk);
    chk("bp_drop_valid", u_if.o_cmd_valid, 1'b0);
    chk("bp_accept_cnt", acc_cmd.size(),   acc_n + 1);
    chk("bp_accept_cmd", acc_cmd[$],       2'b10);
    u_if.i_cmd_ready = 1'b0;
    cycles(8);

    // Overrun: third run pulse hits a still-pending run flag.
    ovr_cnt = 0;
    acc_n   = acc_cmd.size();
    pulse(3'b010);
    cycles(4);
    pulse(3'b010);
    chk("ovr_none_yet", overrun, 1'b0);
    cycles(4);
    pulse(3'b010);
    chk("ovr_pulse",   overrun, 1'b1);
    @(negedge clk);
    chk("ovr_one_cyc", overrun, 1'b0);
    cycles(3);
    chk("ovr_count", ovr_cnt, 1);
    u_if.i_cmd_ready = 1'b1;
    cycles(15);
    chk("ovr_accept_cnt", acc_cmd.size(), acc_n + 2);
    if (acc_cmd.size() == acc_n + 2) begin
      chk("ovr_cmd0", acc_cmd[acc_n],     2'b01);
      chk("ovr_cmd1", acc_cmd[acc_n + 1], 2'b01);
    end

    // Pulse in the grant cycle re-arms the flag, no overrun.
    acc_n   = acc_cmd.size();
    b_clear = 1'b1;
    @(negedge clk);
    @(negedge clk);
    b_clear = 1'b0;
    chk("setwin_pend",  pending,          3'b001);
    chk("setwin_valid", u_if.o_cmd_valid, 1'b1);
    chk("setwin_cmd",   u_if.o_cmd,       2'b10);
    chk("setwin_ovr",   overrun,          1'b0);
    @(negedge clk);
    chk("setwin_ovr2",  overrun,          1'b0);
    cycles(15);
    chk("setwin_accepts", acc_cmd.size(), acc_n + 2);

    // Asynchronous reset in the middle of ISSUE.
    u_if.i_cmd_ready = 1'b0;
    pulse(3'b100);
    wait_valid("rst_mid_timeout");
    pulse(3'b010);
    chk("rst_mid_pre_pend",  pending,          3'b010);
    chk("rst_mid_pre_valid", u_if.o_cmd_valid, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_valid",   u_if.o_cmd_valid, 1'b0);
    chk("rst_mid_cmd",     u_if.o_cmd,       2'b00);
    chk("rst_mid_pending", pending,          3'b000);
    chk("rst_mid_overrun", overrun,          1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_n            = 1'b1;
    u_if.i_cmd_ready = 1'b1;
    valid_cnt        = 0;
    cycles(12);
    chk("rst_mid_no_cmd", valid_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
